// File: rtl/tl_instruction_fetch.sv
// tl_instruction_fetch: MIPS IF stage with loadable program memory, IF/ID register and HALT detection (optional IF_STEP_MODE_EN adds i_step single-stepping)
module tl_instruction_fetch #(
  parameter int LEN = 32,
  parameter int CANTIDAD_INSTRUCCIONES = 256,
  parameter int NB_ADDR_MEM = $clog2(CANTIDAD_INSTRUCCIONES),
  parameter logic [LEN-1:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic                   i_load_en,
  input  logic [NB_ADDR_MEM-1:0] i_load_addr,
  input  logic [LEN-1:0]         i_load_data,
  input  logic                   i_flag_stall,
  input  logic                   i_flag_jump,
  input  logic [LEN-1:0]         i_dir_jump,
  input  logic                   i_flag_branch,
  input  logic [LEN-1:0]         i_dir_branch,
`ifdef IF_STEP_MODE_EN
  input  logic                   i_step,
`endif
  output logic [LEN-1:0]         o_instruccion,
  output logic [LEN-1:0]         o_adder_pc,
  output logic [LEN-1:0]         o_pc,
  output logic                   o_valid,
  output logic                   o_halt,
  output logic [1:0]             o_state
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HALT = 2'b10} state_t;
  state_t state, state_n;
  logic [LEN-1:0] mem [CANTIDAD_INSTRUCCIONES];
  logic [LEN-1:0] pc, pc_n, ins, ins_n, add, add_n, word, pc4;
  logic valid, valid_n, step, we, unused;
`ifdef IF_STEP_MODE_EN
  assign step = i_step;
`else
  assign step = 1'b1;
`endif
  // PC[1:0] and bits above the word index do not select a memory word
  assign unused = ^{pc[LEN-1:NB_ADDR_MEM+2], pc[1:0]};
  assign word = mem[pc[NB_ADDR_MEM+1:2]];
  assign pc4 = pc + LEN'(4);
  assign we = (state == IDLE) && i_load_en && !i_rst;
  assign o_instruccion = ins;
  assign o_adder_pc = add;
  assign o_pc = pc;
  assign o_valid = valid;
  assign o_halt = (state == HALT);
  assign o_state = state;
  // program memory write port, only open while idle; contents survive reset
  always_ff @(posedge i_clk)
    if (we) mem[i_load_addr] <= i_load_data;
  // state, PC and IF/ID registers
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state <= IDLE;
      pc    <= '0;
      ins   <= '0;
      add   <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      ins   <= ins_n;
      add   <= add_n;
      valid <= valid_n;
    end
  // next-state: branch beats stall beats jump beats sequential fetch
  always_comb begin
    state_n = state;
    pc_n    = pc;
    ins_n   = ins;
    add_n   = add;
    valid_n = valid;
    case (state)
      IDLE: begin
        ins_n   = '0;
        valid_n = 1'b0;
        state_n = i_start ? RUN : IDLE;
      end
      RUN: begin
        if (i_flag_branch) begin
          pc_n    = i_dir_branch;
          ins_n   = '0;
          valid_n = 1'b0;
        end else if (!i_flag_stall && step) begin
          if (i_flag_jump) begin
            pc_n    = i_dir_jump;
            ins_n   = '0;
            valid_n = 1'b0;
          end else begin
            ins_n   = word;
            add_n   = pc4;
            valid_n = 1'b1;
            pc_n    = (word == HALT_WORD) ? pc : pc4;
            state_n = (word == HALT_WORD) ? HALT : RUN;
          end
        end
      end
      default: begin
        ins_n   = '0;
        valid_n = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_tl_instruction_fetch.sv
// tb_tl_instruction_fetch: table-driven scoreboard bench for the IF stage
module tb_tl_instruction_fetch;
  localparam logic [31:0] H = 32'hFFFFFFFF;
  logic clk = 0;
  logic rst = 0, start = 0, ld = 0, stall = 0, jump = 0, br = 0, step = 1;
  logic [7:0] la = 0;
  logic [31:0] ldd = 0, dj = 0, db = 0;
  logic [31:0] ins, add, pc;
  logic v, h;
  logic [1:0] st;
  int checks = 0, errors = 0, row = 0;

  typedef struct {
    logic rst, start, ld;
    logic [7:0] la;
    logic [31:0] ldd;
    logic stall, jump;
    logic [31:0] dj;
    logic br;
    logic [31:0] db, ins, add;
    logic ca;
    logic [31:0] pc;
    logic v, h;
    logic [1:0] st;
  } vec_t;
  vec_t tbl[$];
  vec_t sb[$];

  tl_instruction_fetch dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_load_en(ld), .i_load_addr(la),
    .i_load_data(ldd), .i_flag_stall(stall), .i_flag_jump(jump), .i_dir_jump(dj),
    .i_flag_branch(br), .i_dir_branch(db),
`ifdef IF_STEP_MODE_EN
    .i_step(step),
`endif
    .o_instruccion(ins), .o_adder_pc(add), .o_pc(pc), .o_valid(v), .o_halt(h), .o_state(st)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%h want=%h", n, a, e);
    end
  endtask

  task automatic r(input logic r_, input logic s_, input logic l_, input logic [7:0] la_,
                   input logic [31:0] ld_, input logic st_, input logic j_, input logic [31:0] dj_,
                   input logic b_, input logic [31:0] db_, input logic [31:0] ei, input logic [31:0] ea,
                   input logic ca, input logic [31:0] ep, input logic ev, input logic eh,
                   input logic [1:0] es);
    tbl.push_back('{r_, s_, l_, la_, ld_, st_, j_, dj_, b_, db_, ei, ea, ca, ep, ev, eh, es});
  endtask

  task automatic compare(input vec_t e);
    chk($sformatf("row%0d ins", row), ins, e.ins);
    if (e.ca) chk($sformatf("row%0d adder_pc", row), add, e.add);
    chk($sformatf("row%0d pc", row), pc, e.pc);
    chk($sformatf("row%0d valid", row), 32'(v), 32'(e.v));
    chk($sformatf("row%0d halt", row), 32'(h), 32'(e.h));
    chk($sformatf("row%0d state", row), 32'(st), 32'(e.st));
    row++;
  endtask

  task automatic apply(input vec_t x);
    rst = x.rst; start = x.start; ld = x.ld; la = x.la; ldd = x.ldd;
    stall = x.stall; jump = x.jump; dj = x.dj; br = x.br; db = x.db;
  endtask

  initial begin
    bit seen;
    int p;
    // reset and program load
    r(1,0,0,0,0, 0,0,0,0,0, 0,0,1,0,0,0,0);
    r(0,0,1,0,32'h20010005, 0,0,0,0,0, 0,0,1,0,0,0,0);
    r(0,0,1,1,32'h20020007, 0,0,0,0,0, 0,0,1,0,0,0,0);
    r(0,0,1,2,32'h00221820, 0,0,0,0,0, 0,0,1,0,0,0,0);
    r(0,0,1,3,H,            0,0,0,0,0, 0,0,1,0,0,0,0);
    r(0,0,1,8,32'h22222222, 0,0,0,0,0, 0,0,1,0,0,0,0);
    r(0,0,1,9,32'h33333333, 0,0,0,0,0, 0,0,1,0,0,0,0);
    r(0,0,1,16,32'h11111111,0,0,0,0,0, 0,0,1,0,0,0,0);
    r(0,0,1,255,32'h55555555,0,0,0,0,0,0,0,1,0,0,0,0);
    // load and start together
    r(0,1,1,17,32'h44444444,0,0,0,0,0, 0,0,1,0,0,0,1);
    // straight-line fetch, stall at 0x8, halt
    r(0,0,0,0,0, 0,0,0,0,0, 32'h20010005,4,1,4,1,0,1);
    r(0,0,0,0,0, 0,0,0,0,0, 32'h20020007,8,1,8,1,0,1);
    r(0,0,0,0,0, 1,0,0,0,0, 32'h20020007,8,1,8,1,0,1);
    r(0,0,0,0,0, 1,1,32'h40,0,0, 32'h20020007,8,1,8,1,0,1);
    r(0,1,1,1,32'hDEADBEEF, 1,0,0,0,0, 32'h20020007,8,1,8,1,0,1);
    r(0,0,0,0,0, 0,0,0,0,0, 32'h00221820,12,1,12,1,0,1);
    r(0,0,0,0,0, 0,0,0,0,0, H,16,1,12,1,1,2);
    r(0,0,0,0,0, 1,0,0,1,32'h20, 0,0,0,12,0,1,2);
    r(0,1,0,0,0, 0,1,32'h40,0,0, 0,0,0,12,0,1,2);
    r(1,0,0,0,0, 0,0,0,0,0, 0,0,1,0,0,0,0);
    // jump, then branch+stall+jump, load ignored in RUN
    r(0,1,0,0,0, 0,0,0,0,0, 0,0,1,0,0,0,1);
    r(0,0,0,0,0, 0,1,32'h40,0,0, 0,0,0,32'h40,0,0,1);
    r(0,0,0,0,0, 0,0,0,0,0, 32'h11111111,32'h44,1,32'h44,1,0,1);
    r(0,0,0,0,0, 0,0,0,0,0, 32'h44444444,32'h48,1,32'h48,1,0,1);
    r(0,0,0,0,0, 1,1,32'h40,1,32'h20, 0,0,0,32'h20,0,0,1);
    r(0,0,0,0,0, 0,0,0,0,0, 32'h22222222,32'h24,1,32'h24,1,0,1);
    r(0,0,1,1,32'hDEADBEEF, 0,0,0,0,0, 32'h33333333,32'h28,1,32'h28,1,0,1);
    r(1,0,0,0,0, 0,0,0,0,0, 0,0,1,0,0,0,0);
    // restart: program intact, PC wrap, unaligned target
    r(0,1,0,0,0, 0,0,0,0,0, 0,0,1,0,0,0,1);
    r(0,0,0,0,0, 0,0,0,0,0, 32'h20010005,4,1,4,1,0,1);
    r(0,0,0,0,0, 0,0,0,0,0, 32'h20020007,8,1,8,1,0,1);
    r(0,0,0,0,0, 0,0,0,1,32'hFFFFFFFC, 0,0,0,32'hFFFFFFFC,0,0,1);
    r(0,0,0,0,0, 0,0,0,0,0, 32'h55555555,0,1,0,1,0,1);
    r(0,0,0,0,0, 0,0,0,0,0, 32'h20010005,4,1,4,1,0,1);
    r(0,0,0,0,0, 0,0,0,1,32'h42, 0,0,0,32'h42,0,0,1);
    r(0,0,0,0,0, 0,0,0,0,0, 32'h11111111,32'h46,1,32'h46,1,0,1);
    r(1,0,0,0,0, 0,0,0,0,0, 0,0,1,0,0,0,0);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      if (sb.size() > 0) compare(sb.pop_front());
      apply(tbl[i]);
      sb.push_back(tbl[i]);
    end
    @(negedge clk);
    if (sb.size() > 0) compare(sb.pop_front());
    apply('{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0});
    // run the program freely until HALT, bounded
    start = 1;
    @(negedge clk);
    start = 0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = h;
    end
    chk("halt_reached", 32'(seen), 1);
    chk("halt_pc", pc, 32'hC);
    chk("halt_ins", ins, H);
    chk("halt_valid", 32'(v), 1);
    @(negedge clk);
    chk("halt_drain_ins", ins, 0);
    chk("halt_drain_valid", 32'(v), 0);
    chk("halt_hold_pc", pc, 32'hC);
`ifdef IF_STEP_MODE_EN
    rst = 1;
    @(negedge clk);
    rst = 0; start = 1;
    @(negedge clk);
    start = 0;
    p = 0;
    for (int k = 0; k < 12; k++) begin
      step = (k % 4 == 0);
      if (step) p++;
      @(negedge clk);
      chk($sformatf("step%0d pc", k), pc, 32'(4 * p));
    end
    step = 1;
`else
    p = 0;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
